seq_reduce_modp: RTL and testbench
==================================

# seq_reduce_modp

Sequential reducer modulo p = 2^N − C (default 2^255 − 19). It takes the full 2N-bit product from the sequential multiplier and returns the N-bit canonical residue in [0, p). It is the downstream consumer of the multiplier in the field-arithmetic path. Reduction is done by repeated folding (2^N ≡ C mod p) followed by one conditional subtraction, with a valid/ready handshake on both sides.

## Interface
- N, default 255: field width; p = 2^N − C.
- C, default 19: fold constant.
  - Legal range is 1 ≤ C < 32 and N ≥ 16.
  - In this range at most 3 folds are ever needed.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- n  input  2N  value to reduce; sampled only on acceptance.
- in_valid  input  1  n is valid.
- in_ready  output  1  block can accept; high exactly when the state is IDLE.
- r  output  N  residue n mod p; registered.
- out_valid  output  1  r is valid; high exactly when the state is DONE.
- out_ready  input  1  consumer takes r.

## Operation
- Internal working register x is 2N bits wide.
  - hi(x) = x[2N−1:N].
  - lo(x) = x[N−1:0].
- Fold: f = lo(x) + C·hi(x), zero-extended to 2N bits.
  - The product C·hi is N+5 bits wide; no overflow is possible.
- States: IDLE, FOLD, SUB, DONE.
- IDLE
  - in_ready = 1.
  - When in_valid, on the clock edge: x ← n, go to FOLD.
- FOLD
  - Each cycle x ← f.
  - If hi(f) == 0, go to SUB; otherwise stay in FOLD.
  - Example: an input with hi(n) = 0 spends exactly 1 FOLD cycle (identity fold).
- SUB
  - One cycle: x ← (x ≥ p) ? x − p : x.
  - Then go to DONE.
  - On entry x < 2^N, so a single subtraction always lands in [0, p).
- DONE
  - out_valid = 1 and r holds lo(x); r is loaded at the SUB edge.
  - When out_ready, go to IDLE.
- r keeps its last value after the handshake and through IDLE. It is only reloaded at the next SUB edge.
- No pass-through path: in_ready is 0 in DONE, so a new input is accepted at the earliest one cycle after the output handshake.
- Back-pressure: while out_ready = 0 in DONE, r and out_valid hold, and in_valid is ignored.

## Timing
- Reset (asynchronous, immediate) from any state, including mid-FOLD or SUB:
  - state = IDLE, x = 0, r = 0.
  - out_valid = 0, in_ready = 1.
  - Any in-flight operand is discarded.
- Acceptance happens at edge t0.
- out_valid rises after edge t0+F+1, where F is the number of FOLD cycles (1 ≤ F ≤ 3).
  - Minimum latency is 2 cycles.
  - Maximum latency is 4 cycles.
  - Example: n = 2^2N − 1 takes F = 3.
- The output handshake at edge t1 returns the block to IDLE; in_ready is high after t1.
- Peak throughput is one reduction per F+3 cycles.

## Configuration
- REDUCE_CONST_TIME_EN
- Defined (constant-time mode):
  - FOLD always runs exactly 3 cycles, tracked by a 2-bit fold counter, regardless of hi(f). Folds with hi = 0 are identities.
  - SUB always takes 1 cycle; the compare/subtract is computed unconditionally and selected by a mux.
  - Latency from acceptance to out_valid is always 4 cycles.
  - Results are identical to the undefined mode.
- Undefined: data-dependent F as described under Operation.

## Test plan
- n = 0
  - Required: r = 0.
  - out_valid 2 cycles after acceptance (4 cycles with REDUCE_CONST_TIME_EN).
- n = p = 2^255 − 19
  - Required: r = 0.
  - F = 1; SUB subtracts; out_valid 2 cycles after acceptance.
- n = 2^255
  - Required: r = 19.
- n = 2^510 − 1
  - Required: r = 360.
  - F = 3; out_valid 4 cycles after acceptance.
- Back-pressure
  - Hold out_ready = 0 for 5 cycles after out_valid, with in_valid = 1 throughout.
  - Required: r and out_valid stable, in_ready = 0, no new acceptance.
  - Release out_ready: in_ready = 1 the next cycle, and the new n is accepted then.
- Reset mid-operation
  - Drop rst_n during FOLD for n = 2^510 − 1.
  - Required (asynchronous): out_valid = 0, r = 0, in_ready = 1.
  - After release, n = 2^255 yields r = 19 with no residue of the aborted operand.

Source files
------------

// File: rtl/seq_reduce_modp_if.sv
// Handshake bundle for the modular reducer: 2N-bit operand in, N-bit residue out.
// in_valid/in_ready and out_valid/out_ready each transfer on a rising edge where both are high.
interface seq_reduce_modp_if #(
    parameter int N = 255
);
    logic [2*N-1:0] n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   r;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output n, in_valid, out_ready,
        input  in_ready, r, out_valid
    );

    modport slave (
        input  n, in_valid, out_ready,
        output in_ready, r, out_valid
    );
endinterface

// File: rtl/seq_reduce_modp.sv
// Sequential reducer modulo p = 2^N - C: fold hi into lo until hi is zero, then one conditional subtract.
// Build option REDUCE_CONST_TIME_EN: always run exactly three folds so latency is data-independent.
module seq_reduce_modp #(
    parameter int N = 255,
    parameter int C = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_reduce_modp_if.slave   bus,
    output logic [1:0]         state_dbg
);
    localparam int W = 2 * N;
    localparam logic [W-1:0]   ONE_W   = W'(1);
    localparam logic [W-1:0]   P_WIDE  = (ONE_W << N) - W'(C);
    localparam logic [N+4:0]   C_WIDE  = (N+5)'(C);

    typedef enum logic [1:0] {IDLE, FOLD, SUB, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   x;
    logic [N-1:0]   r_q;
    logic [N+4:0]   prod;
    logic [W-1:0]   f;
    logic [W-1:0]   sub_res;
    logic           fold_done;

    // C < 32 keeps C*hi within N+5 bits, so the fold sum never overflows 2N bits.
    assign prod    = C_WIDE * {5'b0, x[W-1:N]};
    assign f       = {{N{1'b0}}, x[N-1:0]} + {{(N-5){1'b0}}, prod};
    assign sub_res = (x >= P_WIDE) ? (x - P_WIDE) : x;

`ifdef REDUCE_CONST_TIME_EN
    logic [1:0] fold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fold_cnt <= 2'd0;
        end else if (state == FOLD) begin
            fold_cnt <= fold_cnt + 2'd1;
        end else begin
            fold_cnt <= 2'd0;
        end
    end

    assign fold_done = (fold_cnt == 2'd2);
`else
    assign fold_done = (f[W-1:N] == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid)  state_next = FOLD;
            FOLD: if (fold_done)     state_next = SUB;
            SUB:                     state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // r is loaded only on the SUB edge and otherwise holds, including through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            r_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) x <= bus.n;
                FOLD: x <= f;
                SUB: begin
                    x   <= sub_res;
                    r_q <= sub_res[N-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.r         = r_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_seq_reduce_modp.sv
// Scoreboard bench for seq_reduce_modp: driver pushes the modelled residue and latency,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_seq_reduce_modp;
  localparam int N = 255;
  localparam int C = 19;
  localparam int W = 2 * N;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] P_W = (ONE << N) - W'(C);
`ifdef REDUCE_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  seq_reduce_modp_if #(.N(N)) bus ();

  seq_reduce_modp #(.N(N), .C(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [N-1:0] exp_q[$];
  int lat_q[$];
  int acc_q[$];
  int hold_req = 0;
  int hold_left = 0;
  int hs_cyc = -1;
  bit shown = 1'b0;
  logic [N-1:0] held_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: residue by plain modulo, fold count by repeatedly applying 2^N == C.
  function automatic logic [N-1:0] model_r(input logic [W-1:0] v);
    return N'(v % P_W);
  endfunction

  function automatic int model_lat(input logic [W-1:0] v);
    logic [W-1:0] t;
    int folds;
    if (CT) return 4;
    t = v;
    folds = 0;
    do begin
      t = (t % (ONE << N)) + W'(C) * (t / (ONE << N));
      folds++;
    end while ((t / (ONE << N)) != 0);
    return folds + 1;
  endfunction

  // Monitor: owns out_ready; compares each newly presented result and checks hold behaviour.
  always @(negedge clk) begin
    logic [N-1:0] e;
    int l;
    int a;
    if (!rst_n) begin
      shown = 1'b0;
      hold_left = 0;
      bus.out_ready = 1'b0;
    end else if (bus.out_valid) begin
      if (!shown) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_output", W'(bus.r), '0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          check(bus.r == e, "residue", W'(bus.r), W'(e));
          check(cyc - a == l, "latency", W'(cyc - a), W'(l));
        end
        shown = 1'b1;
        held_r = bus.r;
        if (hold_req > 0) begin
          hold_left = hold_req + 1;
          hold_req = 0;
        end
      end else begin
        check(bus.r == held_r, "hold_r", W'(bus.r), W'(held_r));
      end
      check(bus.in_ready == 1'b0, "busy_in_ready", W'(bus.in_ready), '0);
      if (hold_left > 1) begin
        bus.out_ready = 1'b0;
        hold_left--;
      end else if (hold_left == 1) begin
        bus.out_ready = 1'b1;
        hold_left = 0;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.out_ready) begin
        shown = 1'b0;
        hs_cyc = cyc + 1;
      end
    end else begin
      bus.out_ready = 1'(($urandom_range(0, 1)));
    end
  end

  // Driver: call at a negedge; returns at a negedge with in_valid low.
  task automatic send(input logic [W-1:0] v, input logic [N-1:0] er, input int lat, output int acc);
    int budget;
    bus.n = v;
    bus.in_valid = 1'b1;
    budget = 0;
    acc = -1;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      check(1'b0, "accept_timeout", W'(budget), W'(200));
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back(er);
    lat_q.push_back(lat);
    acc_q.push_back(acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    check(exp_q.size() == 0, "drain_timeout", W'(exp_q.size()), '0);
  endtask

  function automatic logic [W-1:0] rand_operand(input int mode);
    logic [511:0] t;
    logic [W-1:0] v;
    for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
    case (mode)
      0: v = W'(t);
      1: v = W'(t[N-1:0]);
      2: v = P_W - W'(8) + W'($urandom_range(0, 16));
      default: v = (W'($urandom_range(0, 40)) << N) | W'(t[N-1:0]);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_a;
    int acc_b;
    logic [W-1:0] v;
    bus.n = '0;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check(bus.out_valid == 1'b0, "reset_out_valid", W'(bus.out_valid), '0);
    check(bus.in_ready == 1'b1, "reset_in_ready", W'(bus.in_ready), W'(1));
    check(bus.r == '0, "reset_r", W'(bus.r), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send('0, N'(0), CT ? 4 : 2, acc_a);
    send(P_W, N'(0), CT ? 4 : 2, acc_a);
    send(ONE << N, N'(19), CT ? 4 : 2, acc_a);
    send({W{1'b1}}, N'(360), 4, acc_a);
    send(P_W - ONE, N'(P_W - ONE), CT ? 4 : 2, acc_a);
    drain();

    // Back-pressure: hold the result five cycles while the next operand waits on in_valid.
    hold_req = 5;
    send((ONE << N) + W'(5), N'(24), CT ? 4 : 2, acc_a);
    send({W{1'b1}}, N'(360), 4, acc_b);
    check(acc_b == hs_cyc + 1, "accept_after_release", W'(acc_b), W'(hs_cyc + 1));
    drain();

    // Asynchronous reset in the middle of a three-fold reduction.
    send(ONE << N, N'(19), CT ? 4 : 2, acc_a);
    drain();
    send({W{1'b1}}, N'(360), 4, acc_a);
    #2;
    rst_n = 1'b0;
    #1;
    check(bus.out_valid == 1'b0, "midreset_out_valid", W'(bus.out_valid), '0);
    check(bus.r == '0, "midreset_r", W'(bus.r), '0);
    check(bus.in_ready == 1'b1, "midreset_in_ready", W'(bus.in_ready), W'(1));
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(ONE << N, N'(19), CT ? 4 : 2, acc_a);
    drain();

    for (int i = 0; i < 40; i++) begin
      v = rand_operand(int'($urandom_range(0, 3)));
      send(v, model_r(v), model_lat(v), acc_a);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
